// File: rtl/pc_cmp_pkg.sv
// Package for the trap checker.
// Holds the fail-code width and values, plus helpers that size the thread
// index and the watchdog counter from the block parameters.
package pc_cmp_pkg;

    localparam int FAIL_CODE_W = 2;

    localparam logic [FAIL_CODE_W-1:0] FAIL_NONE       = 2'd0;
    localparam logic [FAIL_CODE_W-1:0] FAIL_BAD_TRAP   = 2'd1;
    localparam logic [FAIL_CODE_W-1:0] FAIL_TIMEOUT    = 2'd2;
    localparam logic [FAIL_CODE_W-1:0] FAIL_BAD_THREAD = 2'd3;

    // Width of a thread index; a single-thread build still carries one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold 0..t; a disabled watchdog (t == 0) keeps one bit.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/pc_cmp_thread.sv
// Per-thread PC comparator.
// Compares one thread's retired PC against the good/bad trap addresses.
// Ports:
//   vld            - thread retired this cycle (already gated by done)
//   pc             - retired PC
//   en             - thread is expected to run
//   good_trap_addr - good-trap PC
//   bad_trap_addr  - bad-trap PC
//   good_hit       - enabled thread retired the good-trap PC (and it is not also the bad PC)
//   bad_hit        - enabled thread retired the bad-trap PC
//   dis_hit        - a disabled thread retired anything
module pc_cmp_thread
    import pc_cmp_pkg::*;
#(
    parameter int PC_W = 48
) (
    input  logic            vld,
    input  logic [PC_W-1:0] pc,
    input  logic            en,
    input  logic [PC_W-1:0] good_trap_addr,
    input  logic [PC_W-1:0] bad_trap_addr,
    output logic            good_hit,
    output logic            bad_hit,
    output logic            dis_hit
);

    logic is_good_s;
    logic is_bad_s;

    assign is_good_s = (pc == good_trap_addr);
    assign is_bad_s  = (pc == bad_trap_addr);

    // Bad wins when both trap addresses are programmed to the same PC.
    assign bad_hit  = vld & en & is_bad_s;
    assign good_hit = vld & en & is_good_s & ~is_bad_s;
    assign dis_hit  = vld & ~en;

endmodule

// File: rtl/pc_trap_cmp.sv
// Trap checker top level.
// Watches every thread's retired PC, keeps sticky good-trap flags, runs a
// no-retire watchdog and declares pass/fail. All outputs are registered and
// freeze once done is set, until reset.
// Ports:
//   clk, rst_l     - clock and asynchronous active-low reset
//   good_trap_addr - good-trap PC (quasi-static)
//   bad_trap_addr  - bad-trap PC (quasi-static)
//   thread_en      - mask of threads expected to run (quasi-static)
//   retire_vld     - per-thread retire strobe
//   retire_pc      - packed per-thread PCs, thread i at [i*PC_W +: PC_W]
//   good_mask      - sticky per-thread good-trap flags
//   pass, fail     - verdict; done = pass | fail
//   fail_code      - 0 none, 1 bad trap, 2 timeout, 3 disabled-thread retire
//   fail_thread    - thread that caused the fail (0 for timeout)
module pc_trap_cmp
    import pc_cmp_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int PC_W        = 48,
    parameter int TIMEOUT     = 100000
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic [PC_W-1:0]               good_trap_addr,
    input  logic [PC_W-1:0]               bad_trap_addr,
    input  logic [NUM_THREADS-1:0]        thread_en,
    input  logic [NUM_THREADS-1:0]        retire_vld,
    input  logic [NUM_THREADS*PC_W-1:0]   retire_pc,
    output logic [NUM_THREADS-1:0]        good_mask,
    output logic                          pass,
    output logic                          fail,
    output logic                          done,
    output logic [FAIL_CODE_W-1:0]        fail_code,
    output logic [idx_width(NUM_THREADS)-1:0] fail_thread
);

    localparam int TW = idx_width(NUM_THREADS);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    logic [NUM_THREADS-1:0] good_mask_r;
    logic                   pass_r;
    logic                   fail_r;
    logic                   done_r;
    logic [FAIL_CODE_W-1:0] fail_code_r;
    logic [TW-1:0]          fail_thread_r;
    logic [CW-1:0]          wd_cnt_r;

    logic [NUM_THREADS-1:0] act_vld_s;
    logic [NUM_THREADS-1:0] good_hit_s;
    logic [NUM_THREADS-1:0] bad_hit_s;
    logic [NUM_THREADS-1:0] dis_hit_s;

    logic                   bad_any_s;
    logic                   dis_any_s;
    logic [TW-1:0]          bad_idx_s;
    logic [TW-1:0]          dis_idx_s;

    logic [CW-1:0]          wd_next_s;
    logic                   timeout_s;

    logic [NUM_THREADS-1:0] gm_next_s;
    logic                   fail_evt_s;
    logic                   pass_evt_s;
    logic [FAIL_CODE_W-1:0] fail_code_s;
    logic [TW-1:0]          fail_thread_s;

    // Once done, no retirement counts as activity.
    assign act_vld_s = retire_vld & {NUM_THREADS{~done_r}};

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
        pc_cmp_thread #(
            .PC_W (PC_W)
        ) u_thr (
            .vld            (act_vld_s[g]),
            .pc             (retire_pc[g*PC_W +: PC_W]),
            .en             (thread_en[g]),
            .good_trap_addr (good_trap_addr),
            .bad_trap_addr  (bad_trap_addr),
            .good_hit       (good_hit_s[g]),
            .bad_hit        (bad_hit_s[g]),
            .dis_hit        (dis_hit_s[g])
        );
    end

    // Lowest-index encoders: scanning downward lets the lowest hit overwrite.
    always_comb begin
        bad_idx_s = '0;
        dis_idx_s = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            bad_idx_s = bad_hit_s[i] ? TW'(i) : bad_idx_s;
            dis_idx_s = dis_hit_s[i] ? TW'(i) : dis_idx_s;
        end
    end

    assign bad_any_s = |bad_hit_s;
    assign dis_any_s = |dis_hit_s;

    // Watchdog next value: clear on any retirement, else count up, saturating.
    always_comb begin
        wd_next_s = wd_cnt_r;
        timeout_s = 1'b0;
        if (TIMEOUT == 0) begin
            wd_next_s = '0;
            timeout_s = 1'b0;
        end else if (|retire_vld) begin
            wd_next_s = '0;
            timeout_s = 1'b0;
        end else if (wd_cnt_r == TIMEOUT_C) begin
            wd_next_s = wd_cnt_r;
            timeout_s = 1'b1;
        end else begin
            wd_next_s = wd_cnt_r + CW'(1);
            timeout_s = (wd_next_s == TIMEOUT_C);
        end
    end

    // Verdict for this cycle: fail priority bad > disabled > timeout, fail beats pass.
    always_comb begin
        gm_next_s     = good_mask_r | good_hit_s;
        fail_evt_s    = bad_any_s | dis_any_s | timeout_s;
        fail_code_s   = FAIL_NONE;
        fail_thread_s = '0;
        if (bad_any_s) begin
            fail_code_s   = FAIL_BAD_TRAP;
            fail_thread_s = bad_idx_s;
        end else if (dis_any_s) begin
            fail_code_s   = FAIL_BAD_THREAD;
            fail_thread_s = dis_idx_s;
        end else if (timeout_s) begin
            fail_code_s   = FAIL_TIMEOUT;
            fail_thread_s = '0;
        end else begin
            fail_code_s   = FAIL_NONE;
            fail_thread_s = '0;
        end
        pass_evt_s = ~fail_evt_s & (|thread_en) &
                     ((gm_next_s & thread_en) == thread_en);
    end

    // State update; everything holds once a verdict has been reached.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            good_mask_r   <= '0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            done_r        <= 1'b0;
            fail_code_r   <= FAIL_NONE;
            fail_thread_r <= '0;
            wd_cnt_r      <= '0;
        end else if (!done_r) begin
            good_mask_r   <= gm_next_s;
            pass_r        <= pass_evt_s;
            fail_r        <= fail_evt_s;
            done_r        <= pass_evt_s | fail_evt_s;
            fail_code_r   <= fail_code_s;
            fail_thread_r <= fail_thread_s;
            wd_cnt_r      <= wd_next_s;
        end
    end

    assign good_mask   = good_mask_r;
    assign pass        = pass_r;
    assign fail        = fail_r;
    assign done        = done_r;
    assign fail_code   = fail_code_r;
    assign fail_thread = fail_thread_r;

endmodule

// File: tb/tb_pc_trap_cmp.sv
// Self-checking bench for pc_trap_cmp: table of single-cycle vectors,
// directed multi-cycle sequences, and randomized runs against a model.
module tb_pc_trap_cmp;

    localparam int NT = 4;
    localparam int PW = 48;
    localparam int TO = 50;

    logic              clk = 1'b0;
    logic              rst_l;
    logic [PW-1:0]     good_trap_addr;
    logic [PW-1:0]     bad_trap_addr;
    logic [NT-1:0]     thread_en;
    logic [NT-1:0]     retire_vld;
    logic [NT*PW-1:0]  retire_pc;
    logic [NT-1:0]     good_mask;
    logic              pass;
    logic              fail;
    logic              done;
    logic [1:0]        fail_code;
    logic [1:0]        fail_thread;

    int checks = 0;
    int errors = 0;

    localparam logic [PW-1:0] GOOD_A = 48'h0000_8000_1000;
    localparam logic [PW-1:0] BAD_A  = 48'h0000_8000_2000;

    logic [PW-1:0] pcs [NT];

    // model state
    logic [NT-1:0] m_gm;
    logic          m_pass;
    logic          m_fail;
    int            m_code;
    int            m_thr;
    int            m_idle;

    pc_trap_cmp #(
        .NUM_THREADS (NT),
        .PC_W        (PW),
        .TIMEOUT     (TO)
    ) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .good_trap_addr (good_trap_addr),
        .bad_trap_addr  (bad_trap_addr),
        .thread_en      (thread_en),
        .retire_vld     (retire_vld),
        .retire_pc      (retire_pc),
        .good_mask      (good_mask),
        .pass           (pass),
        .fail           (fail),
        .done           (done),
        .fail_code      (fail_code),
        .fail_thread    (fail_thread)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] sel_pc(input logic [1:0] s);
        logic [63:0] r;
        logic [PW-1:0] p;
        r = {$urandom(), $urandom()};
        p = r[PW-1:0];
        if (p == good_trap_addr || p == bad_trap_addr) p = p ^ 48'h1;
        case (s)
            2'd0:    return good_trap_addr;
            2'd1:    return bad_trap_addr;
            2'd3:    return good_trap_addr ^ {1'b1, 47'd0};
            default: return p;
        endcase
    endfunction

    task automatic drive(input logic [NT-1:0] en, input logic [NT-1:0] v);
        thread_en  = en;
        retire_vld = v;
        for (int i = 0; i < NT; i++) retire_pc[i*PW +: PW] = pcs[i];
    endtask

    task automatic model_reset();
        m_gm = '0; m_pass = 1'b0; m_fail = 1'b0;
        m_code = 0; m_thr = 0; m_idle = 0;
    endtask

    // Apply the rules directly to the inputs currently on the pins.
    task automatic model_step();
        int bad_t, dis_t;
        logic [NT-1:0] ng;
        if (m_pass || m_fail) return;
        bad_t = -1; dis_t = -1; ng = m_gm;
        for (int i = 0; i < NT; i++) begin
            if (retire_vld[i]) begin
                if (!thread_en[i]) begin
                    if (dis_t < 0) dis_t = i;
                end else if (pcs[i] == bad_trap_addr) begin
                    if (bad_t < 0) bad_t = i;
                end else if (pcs[i] == good_trap_addr) begin
                    ng[i] = 1'b1;
                end
            end
        end
        if (retire_vld != '0) m_idle = 0;
        else if (m_idle < TO) m_idle++;
        m_gm = ng;
        if (bad_t >= 0) begin
            m_fail = 1'b1; m_code = 1; m_thr = bad_t;
        end else if (dis_t >= 0) begin
            m_fail = 1'b1; m_code = 3; m_thr = dis_t;
        end else if (m_idle >= TO) begin
            m_fail = 1'b1; m_code = 2; m_thr = 0;
        end else if (thread_en != '0 && (ng & thread_en) == thread_en) begin
            m_pass = 1'b1;
        end
    endtask

    task automatic tick();
        for (int i = 0; i < NT; i++) retire_pc[i*PW +: PW] = pcs[i];
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/good_mask"},   good_mask,   m_gm);
        chk({tag, "/pass"},        pass,        m_pass);
        chk({tag, "/fail"},        fail,        m_fail);
        chk({tag, "/done"},        done,        m_pass | m_fail);
        chk({tag, "/fail_code"},   fail_code,   m_code);
        chk({tag, "/fail_thread"}, fail_thread, m_thr);
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        for (int i = 0; i < NT; i++) pcs[i] = '0;
        drive('0, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] en;
        logic [3:0] vld;
        logic [7:0] sel;   // 2 bits per thread: 0 good, 1 bad, 2 random, 3 near-good
        logic       same;  // program bad address equal to good
        logic [3:0] gm;
        logic       ps;
        logic       fl;
        logic [1:0] code;
        logic [1:0] thr;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{4'b0011, 4'b0001, 8'b10_10_10_00, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{4'b0001, 4'b0001, 8'b10_10_10_00, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[2]  = '{4'b0111, 4'b0101, 8'b10_01_10_00, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd1, 2'd2};
        vecs[3]  = '{4'b1111, 4'b1010, 8'b01_10_01_10, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd1};
        vecs[4]  = '{4'b0001, 4'b1000, 8'b10_10_10_10, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 2'd3};
        vecs[5]  = '{4'b0001, 4'b1001, 8'b10_10_10_00, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd3, 2'd3};
        vecs[6]  = '{4'b0001, 4'b0011, 8'b10_10_01_01, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[7]  = '{4'b0001, 4'b0010, 8'b10_10_00_10, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 2'd1};
        vecs[8]  = '{4'b0001, 4'b0001, 8'b10_10_10_11, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[9]  = '{4'b0000, 4'b0000, 8'b10_10_10_10, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[10] = '{4'b0000, 4'b0100, 8'b10_00_10_10, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 2'd2};
        vecs[11] = '{4'b0011, 4'b0011, 8'b10_10_00_00, 1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[12] = '{4'b0001, 4'b0001, 8'b10_10_10_00, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[13] = '{4'b1100, 4'b1100, 8'b01_10_10_10, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd3};
    end

    initial begin
        logic [7:0] s;
        logic [NT-1:0] v;
        logic [NT-1:0] en;
        good_trap_addr = GOOD_A;
        bad_trap_addr  = BAD_A;
        rst_l = 1'b0;
        thread_en = '0;
        retire_vld = '0;
        retire_pc = '0;
        #1;

        // Table-driven single-cycle vectors.
        for (int k = 0; k < 14; k++) begin
            good_trap_addr = GOOD_A;
            bad_trap_addr  = vecs[k].same ? GOOD_A : BAD_A;
            do_reset();
            if (k == 0) begin
                chk("reset/good_mask", good_mask, 4'b0000);
                chk("reset/done", {pass, fail, done}, 3'b000);
                chk("reset/code_thr", {fail_code, fail_thread}, 4'b0000);
            end
            s = vecs[k].sel;
            for (int i = 0; i < NT; i++) pcs[i] = sel_pc(s[2*i +: 2]);
            drive(vecs[k].en, vecs[k].vld);
            tick();
            chk($sformatf("vec%0d/good_mask", k), good_mask, vecs[k].gm);
            chk($sformatf("vec%0d/pass", k), pass, vecs[k].ps);
            chk($sformatf("vec%0d/fail", k), fail, vecs[k].fl);
            chk($sformatf("vec%0d/done", k), done, vecs[k].ps | vecs[k].fl);
            chk($sformatf("vec%0d/fail_code", k), fail_code, vecs[k].code);
            chk($sformatf("vec%0d/fail_thread", k), fail_thread, vecs[k].thr);
        end
        good_trap_addr = GOOD_A;
        bad_trap_addr  = BAD_A;

        // Good traps at cycles 10 and 20, then freeze, then async reset.
        do_reset();
        pcs[0] = GOOD_A; pcs[1] = GOOD_A;
        for (int c = 1; c <= 20; c++) begin
            drive(4'b0011, (c == 10) ? 4'b0001 : (c == 20) ? 4'b0010 : 4'b0000);
            tick();
            if (c == 10) begin
                chk("seq1/gm_c10", good_mask, 4'b0001);
                chk("seq1/pass_c10", pass, 1'b0);
            end
        end
        chk("seq1/gm_c20", good_mask, 4'b0011);
        chk("seq1/pass_c20", pass, 1'b1);
        chk("seq1/fail_c20", fail, 1'b0);
        pcs[0] = BAD_A;
        drive(4'b0011, 4'b0001);
        tick();
        check_model("seq1_frozen");
        chk("seq1/frozen_code", fail_code, 2'd0);
        @(posedge clk);
        #3;
        rst_l = 1'b0;
        #1;
        chk("seq1/async_reset", {good_mask, pass, fail, done, fail_code, fail_thread}, 11'd0);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        model_reset();

        // Timeout with no retirement: fail exactly at edge TO.
        do_reset();
        drive(4'b0001, 4'b0000);
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) chk("to/fail_before", fail, 1'b0);
        end
        chk("to/fail", fail, 1'b1);
        chk("to/code", fail_code, 2'd2);
        chk("to/thread", fail_thread, 2'd0);
        check_model("to");

        // Retirement at cycle 49 restarts the watchdog.
        do_reset();
        pcs[0] = sel_pc(2'd2);
        for (int k = 1; k <= 2 * TO - 1; k++) begin
            drive(4'b0001, (k == TO - 1) ? 4'b0001 : 4'b0000);
            tick();
            if (k == TO) chk("to49/no_fail_at_50", fail, 1'b0);
            if (k == 2 * TO - 2) chk("to49/fail_before", fail, 1'b0);
        end
        chk("to49/fail", fail, 1'b1);
        chk("to49/code", fail_code, 2'd2);

        // Randomized runs against the model.
        for (int r = 0; r < 30; r++) begin
            do_reset();
            en = 4'($urandom_range(0, 15));
            if (r % 7 == 0) en = 4'b0000;
            for (int c = 0; c < 150; c++) begin
                v = '0;
                if (r % 5 == 4) begin
                    if ($urandom_range(0, 59) == 0) v[$urandom_range(0, NT - 1)] = 1'b1;
                end else begin
                    for (int i = 0; i < NT; i++) begin
                        v[i] = ($urandom_range(0, 99) < 35) && (en[i] || $urandom_range(0, 99) < 3);
                    end
                end
                for (int i = 0; i < NT; i++) begin
                    int w;
                    w = $urandom_range(0, 99);
                    pcs[i] = sel_pc(w < 25 ? 2'd0 : w < 29 ? 2'd1 : w < 40 ? 2'd3 : 2'd2);
                end
                drive(en, v);
                tick();
                check_model($sformatf("rnd%0d_c%0d", r, c));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
